// File: rtl/four_mem_cof_reader_pkg.sv
// Shared types and defaults for the 4-bank coefficient memory reader.
// Also used by the stream skid FIFO.
package four_mem_cof_reader_pkg;

    localparam int DEF_ADDR_WIDTH_4MEM = 14;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int FIFO_DEPTH          = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/four_mem_cof_reader_cof_skid_fifo.sv
// Two-entry FIFO shared by the stream producers.
// Simultaneous push and pop is allowed when full.
module cof_skid_fifo
    import four_mem_cof_reader_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             rd_q;
    logic             wr_q;
    logic [1:0]       count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == 2'(FIFO_DEPTH));
    assign empty   = (count_q == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign head    = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/four_mem_cof_reader.sv
// Streams LEN words from the 4-bank coefficient memory onto a
// valid/ready interface, absorbing the 1-cycle read latency.
module four_mem_cof_reader
    import four_mem_cof_reader_pkg::*;
#(
    parameter int ADDR_WIDTH_4MEM = DEF_ADDR_WIDTH_4MEM,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH_4MEM-1:0] base_addr,
    input  logic [ADDR_WIDTH_4MEM:0]   len,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH_4MEM-1:0] mem_addr,
    output logic                       mem_addr_sel,
    output logic                       mem_cen_sel,
    output logic                       mem_wen,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic [DATA_WIDTH-1:0]      cof_data,
    output logic                       cof_valid,
    input  logic                       cof_ready
);

    localparam logic [ADDR_WIDTH_4MEM:0] REM_ONE = 1;

    state_e                     state_q;
    state_e                     state_d;
    logic [ADDR_WIDTH_4MEM-1:0] addr_ptr_q;
    logic [ADDR_WIDTH_4MEM-1:0] last_addr_q;
    logic [ADDR_WIDTH_4MEM:0]   remaining_q;
    logic                       inflight_q;
    logic                       zero_done_q;
    logic [1:0]                 fifo_count;
    logic                       fifo_empty;
    logic                       pop;
    logic                       issue;
    logic                       drain_done;
    logic                       accept;

    assign busy         = (state_q != IDLE);
    assign mem_addr_sel = busy;
    assign mem_wen      = 1'b0;
    assign mem_cen_sel  = issue;
    assign mem_addr     = issue ? addr_ptr_q : last_addr_q;
    assign cof_valid    = !fifo_empty;
    assign pop          = cof_valid && cof_ready;
    assign done         = zero_done_q || drain_done;
    assign accept       = (state_q == IDLE) && start && (len != '0);

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = RUN;
            end
            RUN: begin
                // Occupancy after this cycle's pop must leave room for the new read.
                issue = (remaining_q != '0) &&
                        (({1'b0, fifo_count} + 3'(inflight_q)) < (3'd2 + 3'(pop)));
                if (issue && remaining_q == REM_ONE) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && fifo_count == 2'd1 && !inflight_q) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_ptr_q  <= '0;
            last_addr_q <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= issue;
            zero_done_q <= (state_q == IDLE) && start && (len == '0);
            if (accept) begin
                addr_ptr_q  <= base_addr;
                remaining_q <= len;
            end else if (issue) begin
                addr_ptr_q  <= addr_ptr_q + ADDR_WIDTH_4MEM'(1);
                remaining_q <= remaining_q - REM_ONE;
                last_addr_q <= addr_ptr_q;
            end
        end
    end

    cof_skid_fifo #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (mem_rdata),
        .pop       (pop),
        .count     (fifo_count),
        .head      (cof_data),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_four_mem_cof_reader.sv
// Directed bench for four_mem_cof_reader with a 1-cycle-latency memory model.
module tb_four_mem_cof_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] len;
    logic        busy;
    logic        done;
    logic [13:0] mem_addr;
    logic        mem_addr_sel;
    logic        mem_cen_sel;
    logic        mem_wen;
    logic [31:0] mem_rdata;
    logic [31:0] cof_data;
    logic        cof_valid;
    logic        cof_ready;

    int n_assert = 0;
    int n_fail   = 0;

    int          iss_cnt, hs_cnt, done_cnt, done_hs, max_buf, lag1, lag2;
    logic [13:0] iss_q [$];
    logic [31:0] got_q [$];

    always #5 clk = ~clk;

    four_mem_cof_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_addr_sel (mem_addr_sel),
        .mem_cen_sel  (mem_cen_sel),
        .mem_wen      (mem_wen),
        .mem_rdata    (mem_rdata),
        .cof_data     (cof_data),
        .cof_valid    (cof_valid),
        .cof_ready    (cof_ready)
    );

    function automatic logic [31:0] word(input logic [13:0] a);
        return {6'h2C, a[13:12], 10'h155, a};
    endfunction

    // Memory model: data is valid only the cycle after an access.
    always @(posedge clk) begin
        mem_rdata <= mem_cen_sel ? word(mem_addr) : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        #2;
        if (lag2 - hs_cnt > max_buf) max_buf = lag2 - hs_cnt;
        if (mem_cen_sel) begin
            iss_cnt++;
            iss_q.push_back(mem_addr);
        end
        if (cof_valid && cof_ready) begin
            hs_cnt++;
            got_q.push_back(cof_data);
        end
        if (done) begin
            done_cnt++;
            done_hs = hs_cnt;
        end
        lag2 = lag1;
        lag1 = iss_cnt;
    end

    task automatic clear_mon();
        iss_cnt  = 0;
        hs_cnt   = 0;
        done_cnt = 0;
        done_hs  = -1;
        max_buf  = 0;
        lag1     = 0;
        lag2     = 0;
        iss_q.delete();
        got_q.delete();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stream(input string tag, input logic [13:0] base,
                              input int n);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk({tag, "_word"}, 64'(got_q[i]), 64'(word(base + 14'(i))));
        end
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_done_hs"}, 64'(done_hs), 64'(n));
    endtask

    task automatic pulse_start(input logic [13:0] b, input logic [14:0] l);
        @(negedge clk);
        clear_mon();
        start     = 1'b1;
        base_addr = b;
        len       = l;
    endtask

    initial begin
        clear_mon();
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        cof_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_sel", 64'(mem_addr_sel), 64'd0);
        chk("rst_cen", 64'(mem_cen_sel), 64'd0);
        chk("rst_wen", 64'(mem_wen), 64'd0);
        chk("rst_valid", 64'(cof_valid), 64'd0);
        chk("rst_data", 64'(cof_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bank crossing, cycle-exact
        pulse_start(14'h0FFE, 15'd4);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("bx_cen", 64'(mem_cen_sel), 64'(k >= 1 && k <= 4));
            if (k <= 4)
                chk("bx_addr", 64'(mem_addr), 64'(14'h0FFE + 14'(k - 1)));
            chk("bx_valid", 64'(cof_valid), 64'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6)
                chk("bx_data", 64'(cof_data), 64'(word(14'h0FFE + 14'(k - 3))));
            chk("bx_done", 64'(done), 64'(k == 6));
            chk("bx_busy", 64'(busy), 64'(k <= 6));
            chk("bx_sel", 64'(mem_addr_sel), 64'(k <= 6));
            chk("bx_wen", 64'(mem_wen), 64'd0);
        end
        @(negedge clk);
        chk_stream("bx", 14'h0FFE, 4);

        // Address wrap
        pulse_start(14'h3FFF, 15'd2);
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("wr_iss", 64'(iss_cnt), 64'd2);
        if (iss_q.size() == 2) begin
            chk("wr_a0", 64'(iss_q[0]), 64'h3FFF);
            chk("wr_a1", 64'(iss_q[1]), 64'h0000);
        end
        chk_stream("wr", 14'h3FFF, 2);

        // Backpressure
        pulse_start(14'h0100, 15'd8);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            start     = 1'b0;
            cof_ready = !(k >= 4 && k <= 15);
            #1;
            if (k == 10) begin
                chk("bp_valid", 64'(cof_valid), 64'd1);
                chk("bp_cen", 64'(mem_cen_sel), 64'd0);
                chk("bp_hs", 64'(hs_cnt), 64'd1);
            end
            if (k == 15) chk("bp_iss_stall", 64'(iss_cnt), 64'd3);
        end
        @(negedge clk);
        chk("bp_max_buf", 64'(max_buf <= 2), 64'd1);
        chk("bp_iss", 64'(iss_cnt), 64'd8);
        chk_stream("bp", 14'h0100, 8);

        // Zero length
        pulse_start(14'h0555, 15'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("z_done", 64'(done), 64'd1);
        chk("z_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        chk("z_done_off", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk("z_iss", 64'(iss_cnt), 64'd0);
        chk("z_done_cnt", 64'(done_cnt), 64'd1);

        // Start while busy is ignored
        pulse_start(14'h0200, 15'd6);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 14'h0300;
        len       = 15'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("sb_iss", 64'(iss_cnt), 64'd6);
        chk("sb_busy", 64'(busy), 64'd0);
        chk_stream("sb", 14'h0200, 6);

        // Reset mid-run
        pulse_start(14'h0400, 15'd8);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        chk("mr_cen", 64'(mem_cen_sel), 64'd0);
        chk("mr_addr", 64'(mem_addr), 64'd0);
        chk("mr_sel", 64'(mem_addr_sel), 64'd0);
        chk("mr_valid", 64'(cof_valid), 64'd0);
        chk("mr_data", 64'(cof_data), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_no_done", 64'(done_cnt), 64'd0);
        pulse_start(14'h2000, 15'd3);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk_stream("mr", 14'h2000, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/four_mem_cof_reader.md
Name: four_mem_cof_reader

Overview:
Read initiator for the 4-bank coefficient memory controller. On a start pulse it streams LEN consecutive words from BASE_ADDR through the controller's address and cen-select interface, then absorbs the controller's fixed 1-cycle read latency. It delivers the words in order on a valid/ready stream to the downstream MFCC datapath (filterbank/DCT stage), with full throughput and lossless backpressure.

Parameters:
ADDR_WIDTH_4MEM, 14, flat word address width; bits [ADDR_WIDTH_4MEM-1:ADDR_WIDTH_4MEM-2] select the bank.
DATA_WIDTH, 32, coefficient word width.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request pulse; sampled only when busy=0
base_addr  input  ADDR_WIDTH_4MEM  first word address, sampled with start
len  input  ADDR_WIDTH_4MEM+1  word count, 0..2^ADDR_WIDTH_4MEM, sampled with start
busy  output  1  transfer in progress
done  output  1  one-cycle pulse when the transfer completes
mem_addr  output  ADDR_WIDTH_4MEM  drives the controller's addr_4_mem_in
mem_addr_sel  output  1  drives system_4mem_addr_sel (1 routes mem_addr)
mem_cen_sel  output  1  drives system_4mem_cen_sel (1 = access this cycle)
mem_wen  output  1  drives system_4mem_wen_in; constant 0 (read)
mem_rdata  input  DATA_WIDTH  controller's data_4_mem_out, valid the cycle after an issue
cof_data  output  DATA_WIDTH  stream data
cof_valid  output  1  stream valid
cof_ready  input  1  stream ready

Behaviour:
- Reset: busy=0, done=0, mem_addr=0, mem_addr_sel=0, mem_cen_sel=0, mem_wen=0, cof_valid=0, cof_data=0. FIFO empty, inflight=0, state IDLE. Reset mid-transfer aborts it; no done pulse.
- FSM:
  - IDLE: start with len≠0 -> RUN, latching addr_ptr=base_addr and remaining=len.
  - IDLE: start with len=0 -> done=1 next cycle, stay IDLE, no memory access.
  - RUN: while remaining>0, issue reads. When the last read has issued -> DRAIN.
  - DRAIN: when the last word completes a cof handshake -> IDLE, with done=1 in that same cycle.
  - start is ignored while busy=1.
- busy=1 in RUN and DRAIN. mem_addr_sel=busy (registered).
- Issue cycle:
  - Outputs: mem_cen_sel=1, mem_addr=addr_ptr.
  - Next cycle: addr_ptr increments modulo 2^ADDR_WIDTH_4MEM (0x3FFF -> 0x0000) and remaining decrements.
  - Outside issue cycles mem_cen_sel=0 and mem_addr holds its last value.
- Read return: inflight is a 1-bit register set on an issue cycle. When inflight=1, mem_rdata is written into the FIFO at that cycle's edge.
- Buffer: 2-entry FIFO.
  - cof_valid = FIFO not empty; cof_data = FIFO head (registered outputs, no combinational path from mem_rdata).
  - Pop occurs on cof_valid & cof_ready.
  - Simultaneous push and pop are allowed.
- Issue rule: issue only if remaining>0 and (count + inflight − pop) < 2. This guarantees no overflow, so no read is ever dropped or repeated.
- Latency: start at cycle 0 -> first issue cycle 1 -> capture edge end of cycle 2 -> cof_valid cycle 3. With cof_ready held at 1, sustained throughput is 1 word/cycle and done coincides with the last handshake.
- Bank crossings are transparent; reads are ordered by issue.

Decomposition:
- Shared package/include: ADDR_WIDTH_4MEM and DATA_WIDTH defaults, FSM state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2), FIFO depth constant (2).
- One sub-module: cof_skid_fifo. It is the 2-entry FIFO with push, pop, count, head; the same interface is reused by other stream producers.

Test Plan:
- Bank cross: base=0x0FFE, len=4, ready=1.
  - Response: mem_addr 0x0FFE, 0x0FFF, 0x1000, 0x1001 on cycles 1–4 with mem_cen_sel=1; cof_valid on cycles 3–6 carrying the model's bank-0, 0, 1, 1 words; done on cycle 6.
- Wrap: base=0x3FFF, len=2.
  - Response: addresses 0x3FFF then 0x0000; two words out in order; done once.
- Backpressure: len=8, cof_ready low from cycle 4 to 15, then high.
  - Response: no more than 2 words buffered; mem_cen_sel stays 0 while full; all 8 words delivered in order with no duplicates; done on the 8th handshake.
- Zero length: start with len=0.
  - Response: done=1 in cycle 1, busy stays 0, mem_cen_sel never asserted.
- Start while busy: second start with different base during a len=6 run.
  - Response: ignored; exactly 6 words from the first base.
- Reset mid-run: assert rst_n=0 during RUN.
  - Response: all outputs 0 immediately, no done.
  - Then a fresh start with base=0x2000, len=3 returns the correct 3 words.
